// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence player.
package seq_pkg;

  localparam int DATA_W        = 8;
  localparam int MAX_CHECK_LAT = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] c_exp;
    logic              chk;
  } entry_t;

endpackage

// File: rtl/seq_mem.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a program survives a reset.
module seq_mem #(
  parameter int DEPTH = 32,
  parameter int DW    = 17
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdat,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdat
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdat;
  end

  assign rdat = mem_q[raddr];

endmodule

// File: rtl/u_sequence_player.sv
// Replays a stored U program into a state machine, one word per clock, and
// checks the machine's C output CHECK_LAT edges later, latching the first mismatch.
module u_sequence_player
  import seq_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int W         = 8,
  parameter int CHECK_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [W-1:0]               wr_u,
  input  logic [W-1:0]               wr_c_exp,
  input  logic                       wr_chk,
  input  logic [$clog2(DEPTH+1)-1:0] len,
  input  logic                       start,
  input  logic                       abort,
  input  logic [W-1:0]               C,
  output logic [W-1:0]               U,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH)-1:0]   err_step
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH+1);
  localparam int EW  = 2*W + 1;
  localparam int LAT = (CHECK_LAT < 1) ? 1 :
                       (CHECK_LAT > MAX_CHECK_LAT) ? MAX_CHECK_LAT : CHECK_LAT;

  state_e          state_q, state_d;
  logic [LW-1:0]   step_q, step_d;
  logic [LW-1:0]   n_q, n_d;
  logic [1:0]      drain_q, drain_d;
  logic [W-1:0]    u_q, u_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [AW-1:0]   err_step_q, err_step_d;

  logic [LAT-1:0]         pv_q, pv_d;
  logic [LAT-1:0][W-1:0]  pc_q, pc_d;
  logic [LAT-1:0]         pk_q, pk_d;
  logic [LAT-1:0][AW-1:0] ps_q, ps_d;

  logic [AW-1:0] rd_addr;
  logic [EW-1:0] rd_dat;
  logic [EW-1:0] start_ent;
  logic [EW-1:0] push_ent;
  logic [AW-1:0] push_step;
  logic          push;
  logic          flush;
  logic          mismatch;
  logic          mem_we;

  assign mem_we  = wr_en & ~busy_q;
  assign rd_addr = (state_q == RUN) ? step_q[AW-1:0] : '0;

  seq_mem #(.DEPTH(DEPTH), .DW(EW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdat  ({wr_u, wr_c_exp, wr_chk}),
    .raddr (rd_addr),
    .rdat  (rd_dat)
  );

  // A write to entry 0 on the start edge must be seen by the first step.
  assign start_ent = (mem_we && wr_addr == '0) ? {wr_u, wr_c_exp, wr_chk} : rd_dat;

  assign mismatch = pv_q[LAT-1] & pk_q[LAT-1] & (C != pc_q[LAT-1]);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    n_d        = n_q;
    drain_d    = drain_q;
    u_d        = u_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_step_d = err_step_q;
    push       = 1'b0;
    push_ent   = rd_dat;
    push_step  = step_q[AW-1:0];
    flush      = 1'b0;

    if (mismatch && !err_q) begin
      err_d      = 1'b1;
      err_step_d = ps_q[LAT-1];
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len == '0) begin
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            n_d        = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
            u_d        = start_ent[EW-1 -: W];
            push       = 1'b1;
            push_ent   = start_ent;
            push_step  = '0;
            step_d     = LW'(1);
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            err_step_d = '0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (step_q == n_q) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          u_d    = rd_dat[EW-1 -: W];
          push   = 1'b1;
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(LAT-1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards in-flight compares, so the flags freeze as they stood.
    if (abort && (state_q == RUN || state_q == DRAIN)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      u_d        = u_q;
      err_d      = err_q;
      err_step_d = err_step_q;
      push       = 1'b0;
      flush      = 1'b1;
    end

    pv_d[0] = push;
    pc_d[0] = push_ent[W:1];
    pk_d[0] = push_ent[0];
    ps_d[0] = push_step;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pc_d[i] = pc_q[i-1];
      pk_d[i] = pk_q[i-1];
      ps_d[i] = ps_q[i-1];
    end
    if (flush) pv_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      n_q        <= '0;
      drain_q    <= '0;
      u_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= '0;
      pv_q       <= '0;
      pc_q       <= '0;
      pk_q       <= '0;
      ps_q       <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      n_q        <= n_d;
      drain_q    <= drain_d;
      u_q        <= u_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
      pv_q       <= pv_d;
      pc_q       <= pc_d;
      pk_q       <= pk_d;
      ps_q       <= ps_d;
    end
  end

  assign U        = u_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_step = err_step_q;

endmodule

// File: tb/tb_u_sequence_player.sv
// Randomised self-checking bench for u_sequence_player (DEPTH=32, W=8, CHECK_LAT=1).
module tb_u_sequence_player;
  import seq_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0, rst = 1'b0;
  logic       wr_en = 1'b0, wr_chk = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_u = '0, wr_c_exp = '0, C = '0;
  logic [5:0] len = '0;
  logic [7:0] U;
  logic       busy, done, err;
  logic [4:0] err_step;

  int errors = 0;
  int checks = 0;

  entry_t     prog [DEPTH];
  logic [7:0] cdrv [DEPTH];
  logic [7:0] last_u = 8'h00;

  u_sequence_player #(.DEPTH(32), .W(8), .CHECK_LAT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_u(wr_u),
    .wr_c_exp(wr_c_exp), .wr_chk(wr_chk), .len(len), .start(start),
    .abort(abort), .C(C), .U(U), .busy(busy), .done(done), .err(err),
    .err_step(err_step)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic write_entry(input int a, input logic [7:0] u, input logic [7:0] c, input logic k);
    wr_en = 1'b1; wr_addr = 5'(a); wr_u = u; wr_c_exp = c; wr_chk = k;
    @(posedge clk); #1;
    wr_en = 1'b0;
    prog[a] = '{u: u, c_exp: c, chk: k};
  endtask

  task automatic load_random();
    for (int a = 0; a < DEPTH; a++) begin
      write_entry(a, 8'($urandom), 8'($urandom), 1'($urandom));
      cdrv[a] = ($urandom_range(3) == 0) ? 8'($urandom) : prog[a].c_exp;
    end
  endtask

  // Plays ln (>0) steps; abort_at>0 aborts on the edge that would issue that step.
  task automatic run_prog(input int ln, input int abort_at, input bit wp);
    int n, first, edges;
    n = (ln > DEPTH) ? DEPTH : ln;
    first = -1;
    start = 1'b1; len = 6'(ln);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    for (int t = 0; t < n; t++) begin
      checks++;
      if (U !== prog[t].u) begin errors++; $display("FAIL run_u step %0d: got %h expected %h", t, U, prog[t].u); end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL run_flags step %0d: busy=%b done=%b expected busy=1 done=0", t, busy, done); end
      C = cdrv[t];
      if (wp && t == 0) begin wr_en = 1'b1; wr_addr = 5'd0; wr_u = 8'hFF; wr_c_exp = 8'hFF; wr_chk = 1'b1; end
      if (t + 1 == abort_at) abort = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (abort) begin
        abort = 1'b0;
        last_u = prog[t].u;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: busy=%b done=%b expected 0 0", busy, done); end
        checks++;
        if (U !== prog[t].u) begin errors++; $display("FAIL abort_u: got %h expected %h", U, prog[t].u); end
        checks++;
        if (err !== (first >= 0)) begin errors++; $display("FAIL abort_err: got %b expected %b", err, first >= 0); end
        return;
      end
      if (first < 0 && prog[t].chk && cdrv[t] !== prog[t].c_exp) first = t;
    end
    edges = n;
    while (done !== 1'b1 && edges < n + 8) begin
      @(posedge clk); #1;
      edges++;
    end
    last_u = prog[n-1].u;
    checks++;
    if (edges != n + 1) begin errors++; $display("FAIL done_latency len=%0d: done after %0d edges expected %0d", ln, edges, n + 1); end
    checks++;
    if (busy !== 1'b0 || U !== prog[n-1].u) begin errors++; $display("FAIL end_state: busy=%b U=%h expected busy=0 U=%h", busy, U, prog[n-1].u); end
    checks++;
    if (err !== (first >= 0)) begin errors++; $display("FAIL end_err: got %b expected %b", err, first >= 0); end
    checks++;
    if (err_step !== 5'((first >= 0) ? first : 0)) begin errors++; $display("FAIL end_err_step: got %0d expected %0d", err_step, (first >= 0) ? first : 0); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (U !== 8'h00) begin errors++; $display("FAIL reset_u: got %h expected 00", U); end
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err}); end
    checks++;
    if (err_step !== 5'd0) begin errors++; $display("FAIL reset_err_step: got %0d expected 0", err_step); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_u = 8'h00;
  endtask

  task automatic test_basic();
    logic [7:0] us [4];
    us[0] = 8'h52; us[1] = 8'h46; us[2] = 8'h05; us[3] = 8'h80;
    for (int a = 0; a < 4; a++) begin
      write_entry(a, us[a], 8'($urandom), 1'b0);
      cdrv[a] = 8'($urandom);
    end
    run_prog(4, 0, 1'b0);
  endtask

  task automatic test_mismatch();
    write_entry(0, 8'($urandom), 8'h33, 1'b1);
    write_entry(1, 8'($urandom), 8'h0C, 1'b1);
    write_entry(2, 8'($urandom), 8'hA7, 1'b1);
    cdrv[0] = 8'h33; cdrv[1] = 8'h00; cdrv[2] = 8'h58;
    run_prog(3, 0, 1'b0);
    checks++;
    if (err !== 1'b1 || err_step !== 5'd1) begin errors++; $display("FAIL mismatch_first: err=%b step=%0d expected err=1 step=1", err, err_step); end
  endtask

  task automatic test_len0();
    start = 1'b1; len = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL len0_done: done=%b err=%b expected 1 0", done, err); end
    checks++;
    if (U !== last_u) begin errors++; $display("FAIL len0_u: got %h expected %h", U, last_u); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy cycle %0d: got %b expected 0", i, busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len40();
    load_random();
    run_prog(40, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_prog(5, 2, 1'b0);
    run_prog(5, 0, 1'b0);
  endtask

  task automatic test_write_protect();
    run_prog(3, 0, 1'b1);
    run_prog(3, 0, 1'b0);
  endtask

  task automatic test_start_with_write();
    wr_en = 1'b1; wr_addr = 5'd0; wr_u = 8'h3C; wr_c_exp = 8'h11; wr_chk = 1'b1;
    prog[0] = '{u: 8'h3C, c_exp: 8'h11, chk: 1'b1};
    cdrv[0] = 8'h11;
    run_prog(2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      load_random();
      run_prog(int'($urandom_range(40, 1)), 0, 1'b0);
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; len = 6'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (U !== 8'h00) begin errors++; $display("FAIL midrun_reset_u: got %h expected 00", U); end
    checks++;
    if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midrun_reset_flags: got %b expected 000", {busy, done, err}); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_u = 8'h00;
    run_prog(4, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_len0();
    test_len40();
    test_abort();
    test_write_protect();
    test_start_with_write();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/u_sequence_player.md
Name: u_sequence_player

Overview:
- Initiator side of the 8-bit U/C control interface of `state_machine`.
- Replays a pre-loaded program of U words into the machine, one per clock.
- Compares the machine's C output against per-step expected values and reports the first mismatch.
- Sits beside `state_machine` as a self-checking stimulus source for bring-up and regression.

Parameters:
- DEPTH, 32, number of program entries.
- W, 8, width of U and C.
- CHECK_LAT, 1, clock edges between driving U for step k and sampling C for step k (1..4).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  program write strobe; honoured only while busy=0.
- wr_addr  in  $clog2(DEPTH)  program entry index.
- wr_u  in  W  U word for the entry.
- wr_c_exp  in  W  expected C for the entry.
- wr_chk  in  1  1 = compare C for this entry, 0 = don't-care.
- len  in  $clog2(DEPTH+1)  number of steps to play, sampled with start.
- start  in  1  begin playback; ignored while busy=1.
- abort  in  1  stop playback.
- C  in  W  output of the driven state machine.
- U  out  W  stimulus to the driven state machine.
- busy  out  1  playback or drain in progress.
- done  out  1  sticky run-complete flag.
- err  out  1  sticky mismatch flag.
- err_step  out  $clog2(DEPTH)  step index of the first mismatch.

Behaviour:
- Reset (async, any time, including mid-run): state IDLE; U=0, busy=0, done=0, err=0, err_step=0; check pipeline flushed. Program memory is not reset.
- States:
  - IDLE: waiting for start.
  - RUN: issuing steps.
  - DRAIN: CHECK_LAT cycles, waiting for the last compares.
  - DONE: done=1, busy=0; accepts a new start exactly like IDLE.
- Program writes: on an edge with wr_en=1 and busy=0, mem[wr_addr] <= {wr_u, wr_c_exp, wr_chk}. Writes while busy=1 are dropped.
- Start, len>0 (edge where start=1 in IDLE/DONE):
  - Latch n = min(len, DEPTH).
  - U <= mem[0].u; step <= 1; busy <= 1; done <= 0; err <= 0; err_step <= 0.
  - Go to RUN.
- Start, len=0: done <= 1, err <= 0, busy stays 0, U unchanged.
- RUN:
  - Each edge: U <= mem[step].u, step increments.
  - The edge that would issue step n instead enters DRAIN; U holds its last value.
  - Each U word is therefore held for exactly one cycle.
- Check pipeline:
  - Step k's {c_exp, chk, k} enters a CHECK_LAT-deep pipe on the same edge that drives U=mem[k].u.
  - At the pipe output, if chk=1 and C != c_exp, and err=0: err <= 1 and err_step <= k.
  - Later mismatches do not overwrite err_step. Playback continues after an error.
- DRAIN: counts CHECK_LAT edges, then done <= 1, busy <= 0, state DONE.
- After a run, U holds the last played word until the next start.
- Abort: on an edge with abort=1 in RUN/DRAIN:
  - State IDLE, busy=0, done=0; U holds its value; check pipe is flushed.
  - err and err_step keep their current values.
  - abort has priority over start and over step advance.
- Simultaneous events:
  - start together with wr_en in IDLE: the write completes; playback reads the new data if wr_addr=0.
  - start while busy=1: ignored.
- Latency:
  - First U is valid one edge after start.
  - done rises n+CHECK_LAT edges after the start edge.

Decomposition:
- Package `seq_pkg`:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - entry struct {u[W], c_exp[W], chk}.
  - Constant MAX_CHECK_LAT=4.
- Sub-module `seq_mem`: DEPTH x (2W+1) register file with one synchronous write port and one combinational read port, addressed by step.
- FSM, step counter and check pipe stay in u_sequence_player.

Test Plan:
- Reset mid-run: start with len=4, assert rst in cycle 2 → U=0, busy=0, done=0, err=0 immediately, without waiting for a clock edge.
- Basic replay: load U = 8'h52, 8'h46, 8'h05, 8'h80 with chk=0; start with len=4 → U shows exactly that sequence on 4 consecutive cycles; done=1 at edge 5 (CHECK_LAT=1); err=0.
- Mismatch capture: 3 steps with chk=1; loopback C is forced wrong only at step 1 (c_exp=8'h0C, C=8'h00) and at step 2 → err=1, err_step=1; done still asserts after the drain.
- Bounds: len=0 → done=1 next edge, busy never rises. len=40 with DEPTH=32 → exactly 32 steps played.
- Abort: abort at step 2 of 5 → busy=0, done=0, U holds mem[1].u; a following start replays from step 0.
- Write protection: wr_en at addr 0 while busy, new value 8'hFF → ignored; the next run still plays the original entry 0.
